// File: rtl/bure_stage_if_fq.sv
// BureCore instruction fetch stage: pipelined imem reads feeding a fetch queue with redirect flush.
// Define BURE_IF_BYPASS_EN to forward a response straight to decode when the queue is empty.
module bure_stage_if_fq #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned INSTR_WIDTH     = 32,
  parameter int unsigned FQ_DEPTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned ADDR_INC        = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_prst,
  input  logic [ADDR_WIDTH-1:0]  i_new_pc,
  output logic                   o_imem_ren,
  output logic [ADDR_WIDTH-1:0]  o_imem_raddr,
  input  logic                   i_imem_rdata_valid,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_instr_pc,
  input  logic                   i_instr_ready
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(ADDR_INC);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]  rsp_pc_q, rsp_pc_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [OUT_W-1:0]       out_q, out_d;
  logic [OUT_W-1:0]       discard_q, discard_d;
  logic [INSTR_WIDTH-1:0] data_q [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_q   [FQ_DEPTH];

  logic run, redirect, rsp_accept, rsp_keep, issue, q_valid, bypass, push, pop;

  assign run        = (state_q == ST_RUN);
  assign redirect   = run && i_prst;
  // Responses with nothing outstanding (e.g. leftovers from before reset) are ignored.
  assign rsp_accept = i_imem_rdata_valid && (out_q != '0);
  assign rsp_keep   = rsp_accept && (discard_q == '0) && !i_prst;
  assign q_valid    = (count_q != '0);

  // Reserve a queue slot for every live in-flight read so no response can overflow.
  assign issue = run && !i_prst && (32'(out_q) < MAX_OUTSTANDING) &&
                 ((32'(count_q) + 32'(out_q) - 32'(discard_q)) < FQ_DEPTH);

`ifdef BURE_IF_BYPASS_EN
  assign bypass = run && rsp_keep && !q_valid;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = run && !i_prst && q_valid && i_instr_ready;
  assign push = rsp_keep && !(bypass && i_instr_ready);

  assign o_imem_ren    = issue;
  assign o_imem_raddr  = fetch_pc_q;
  assign o_instr_valid = run && !i_prst && (q_valid || bypass);
  assign o_instr       = bypass ? i_imem_rdata : data_q[rd_ptr_q];
  assign o_instr_pc    = bypass ? rsp_pc_q : pc_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_d      = out_q;
    discard_d  = discard_q;

    if (!run) begin
      state_d = ST_RUN;
      if (i_prst) begin
        fetch_pc_d = i_new_pc;
        rsp_pc_d   = i_new_pc;
      end
    end else if (redirect) begin
      // Everything still in flight after this cycle is stale.
      fetch_pc_d = i_new_pc;
      rsp_pc_d   = i_new_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      out_d      = out_q - OUT_W'(rsp_accept);
      discard_d  = out_q - OUT_W'(rsp_accept);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + PC_INC;
      out_d = out_q + OUT_W'(issue) - OUT_W'(rsp_accept);
      if (rsp_accept && (discard_q != '0)) discard_d = discard_q - OUT_W'(1);
      if (rsp_keep) rsp_pc_d = rsp_pc_q + PC_INC;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_q      <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
    end
  end

  // Entries are cleared at reset so the head outputs read as zero.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= i_imem_rdata;
      pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

endmodule
